pong_speed_ctrl: RTL and testbench

Sequencing and difficulty controller for the pong datapath. It gates ball motion with `freeze` and runs a 3-2-1 serve countdown on frame ticks. It supports pause/resume and raises ball and paddle speed by level as the rally hit count grows. It sits between the game FSM and the graphics unit, driving their speed and still inputs.

---
 rtl/pong_pkg.sv | 20 ++
 rtl/pong_speed_ctrl_if.sv | 35 +++
 rtl/pong_frame_div.sv | 42 ++++
 rtl/pong_speed_ctrl.sv | 158 +++++++++++++++
 tb/tb_pong_speed_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
// Shared widths and state encoding for the pong sequencing/difficulty
// controller and its interface.
// No ports (package).
// ---------------------------------------------------------------------------
package pong_pkg;

  localparam int LEVEL_W = 3;
  localparam int SPEED_W = 4;
  localparam int DIGIT_W = 2;
  localparam int STATE_W = 2;

  // Encoding is visible on the state output, so keep it fixed.
  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_COUNT  = 2'd1;
  localparam logic [STATE_W-1:0] ST_RUN    = 2'd2;
  localparam logic [STATE_W-1:0] ST_PAUSED = 2'd3;

endpackage

// File: rtl/pong_speed_ctrl_if.sv
// ---------------------------------------------------------------------------
// pong_speed_ctrl_if
// Groups the game-FSM / graphics side signals of pong_speed_ctrl.
//   master : game side, drives frame_tick/new_game/abort/hit/miss/pause_btn,
//            observes freeze, speeds, level, countdown, serve_go, state.
//   slave  : the controller itself (directions reversed).
// ---------------------------------------------------------------------------
interface pong_speed_ctrl_if;
  import pong_pkg::*;

  logic               frame_tick;
  logic               new_game;
  logic               abort;
  logic               hit;
  logic               miss;
  logic               pause_btn;
  logic               freeze;
  logic [SPEED_W-1:0] ball_speed;
  logic [SPEED_W-1:0] paddle_speed;
  logic [LEVEL_W-1:0] level;
  logic [DIGIT_W-1:0] countdown;
  logic               serve_go;
  logic [STATE_W-1:0] state;

  modport master (
    output frame_tick, new_game, abort, hit, miss, pause_btn,
    input  freeze, ball_speed, paddle_speed, level, countdown, serve_go, state
  );

  modport slave (
    input  frame_tick, new_game, abort, hit, miss, pause_btn,
    output freeze, ball_speed, paddle_speed, level, countdown, serve_go, state
  );

endinterface

// File: rtl/pong_frame_div.sv
// ---------------------------------------------------------------------------
// pong_frame_div
// Modulo-FRAMES_PER_COUNT frame-tick counter.
//   clk   : system clock
//   reset : asynchronous, active-high
//   clr   : synchronous clear to 0 (wins over tick)
//   tick  : count enable (one frame tick)
//   wrap  : combinational pulse, tick seen while counter at FRAMES_PER_COUNT-1
// ---------------------------------------------------------------------------
module pong_frame_div #(
  parameter int FRAMES_PER_COUNT = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic tick,
  output logic wrap
);

  localparam int CW = (FRAMES_PER_COUNT > 1) ? $clog2(FRAMES_PER_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_COUNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign wrap = tick & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (tick)
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pong_speed_ctrl.sv
// ---------------------------------------------------------------------------
// pong_speed_ctrl
// Serve countdown, pause and difficulty controller for the pong datapath.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : pong_speed_ctrl_if.slave (game inputs, graphics-side outputs)
// All outputs are registered from the next-state values, so they follow the
// qualifying input cycle by exactly one clock.
// ---------------------------------------------------------------------------
module pong_speed_ctrl
  import pong_pkg::*;
#(
  parameter int HITS_PER_LEVEL   = 4,
  parameter int MAX_LEVEL        = 7,
  parameter int BASE_BALL        = 2,
  parameter int BASE_PAD         = 3,
  parameter int FRAMES_PER_COUNT = 60
) (
  input  logic                    clk,
  input  logic                    reset,
  pong_speed_ctrl_if.slave        bus
);

  localparam int HW = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;
  localparam logic [HW-1:0]      HIT_LAST = HW'(HITS_PER_LEVEL - 1);
  localparam logic [LEVEL_W-1:0] MAX_LVL  = LEVEL_W'(MAX_LEVEL);

  logic [STATE_W-1:0] state_q, state_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic [HW-1:0]      hits_q, hits_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               pause_q;
  logic               serve_go_q, serve_go_d;
  logic               freeze_q, freeze_d;
  logic [DIGIT_W-1:0] countdown_q, countdown_d;
  logic [SPEED_W-1:0] ball_speed_q, ball_speed_d;
  logic [SPEED_W-1:0] paddle_speed_q, paddle_speed_d;

  logic pause_rise;
  logic div_clr, div_tick, div_wrap;

  assign pause_rise = bus.pause_btn & ~pause_q;

  // Counting only happens while already in COUNT; any other cycle (including
  // the entry cycle) holds the divider at 0 so a coincident tick is dropped.
  assign div_tick = bus.frame_tick & (state_q == ST_COUNT);
  assign div_clr  = (state_q != ST_COUNT) | bus.abort;

  pong_frame_div #(
    .FRAMES_PER_COUNT(FRAMES_PER_COUNT)
  ) u_frame_div (
    .clk   (clk),
    .reset (reset),
    .clr   (div_clr),
    .tick  (div_tick),
    .wrap  (div_wrap)
  );

  always_comb begin
    state_d    = state_q;
    digit_d    = digit_q;
    hits_d     = hits_q;
    level_d    = level_q;
    serve_go_d = 1'b0;

    if (bus.abort) begin
      state_d = ST_IDLE;
      level_d = '0;
      hits_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          level_d = '0;
          hits_d  = '0;
          if (bus.new_game) begin
            state_d = ST_COUNT;
            digit_d = 2'd3;
          end
        end
        ST_COUNT: begin
          if (div_wrap) begin
            if (digit_q == 2'd1) begin
              state_d    = ST_RUN;
              serve_go_d = 1'b1;
            end else begin
              digit_d = digit_q - 2'd1;
            end
          end
        end
        ST_RUN: begin
          if (bus.miss) begin
            state_d = ST_COUNT;
            digit_d = 2'd3;
            hits_d  = '0;
            level_d = (level_q == '0) ? level_q : level_q - 1'b1;
          end else if (bus.hit) begin
            if (hits_q == HIT_LAST) begin
              // Hit count keeps wrapping even once the level is saturated.
              hits_d  = '0;
              level_d = (level_q == MAX_LVL) ? level_q : level_q + 1'b1;
            end else begin
              hits_d = hits_q + 1'b1;
            end
          end else if (pause_rise) begin
            state_d = ST_PAUSED;
          end
        end
        default: begin // ST_PAUSED
          if (pause_rise)
            state_d = ST_RUN;
        end
      endcase
    end
  end

  // Output registers are loaded from next-state values.
  always_comb begin
    freeze_d       = (state_d != ST_RUN);
    countdown_d    = (state_d == ST_COUNT) ? digit_d : '0;
    ball_speed_d   = SPEED_W'(BASE_BALL) + SPEED_W'(level_d);
    paddle_speed_d = SPEED_W'(BASE_PAD) + SPEED_W'(level_d >> 1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      digit_q        <= '0;
      hits_q         <= '0;
      level_q        <= '0;
      pause_q        <= 1'b0;
      serve_go_q     <= 1'b0;
      freeze_q       <= 1'b1;
      countdown_q    <= '0;
      ball_speed_q   <= SPEED_W'(BASE_BALL);
      paddle_speed_q <= SPEED_W'(BASE_PAD);
    end else begin
      state_q        <= state_d;
      digit_q        <= digit_d;
      hits_q         <= hits_d;
      level_q        <= level_d;
      pause_q        <= bus.pause_btn;
      serve_go_q     <= serve_go_d;
      freeze_q       <= freeze_d;
      countdown_q    <= countdown_d;
      ball_speed_q   <= ball_speed_d;
      paddle_speed_q <= paddle_speed_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.freeze       = freeze_q;
  assign bus.level        = level_q;
  assign bus.countdown    = countdown_q;
  assign bus.serve_go     = serve_go_q;
  assign bus.ball_speed   = ball_speed_q;
  assign bus.paddle_speed = paddle_speed_q;

endmodule

// File: tb/tb_pong_speed_ctrl.sv
module tb_pong_speed_ctrl;

  localparam int F    = 60;
  localparam int H    = 4;
  localparam int MAXL = 7;
  localparam int BB   = 2;
  localparam int BP   = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pong_speed_ctrl_if bus ();

  pong_speed_ctrl #(
    .HITS_PER_LEVEL  (H),
    .MAX_LEVEL       (MAXL),
    .BASE_BALL       (BB),
    .BASE_PAD        (BP),
    .FRAMES_PER_COUNT(F)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors = 0;
  int errors  = 0;
  logic pb_lvl = 1'b0;

  // Reference model: game-level view with a "ticks left until serve" count.
  int m_state;     // 0 idle, 1 count, 2 run, 3 paused
  int m_level;
  int m_hits;
  int m_left;
  bit m_serve;
  bit m_pprev;

  task automatic model_reset();
    m_state = 0; m_level = 0; m_hits = 0; m_left = 0; m_serve = 0; m_pprev = 0;
  endtask

  task automatic model_step(input bit ft, ng, ab, h, m, pb);
    bit rise;
    rise    = pb && !m_pprev;
    m_pprev = pb;
    m_serve = 0;
    if (ab) begin
      m_state = 0; m_level = 0; m_hits = 0;
    end else if (m_state == 0) begin
      if (ng) begin m_state = 1; m_left = 3 * F; end
    end else if (m_state == 1) begin
      if (ft) begin
        m_left = m_left - 1;
        if (m_left == 0) begin m_state = 2; m_serve = 1; end
      end
    end else if (m_state == 2) begin
      if (m) begin
        m_state = 1; m_left = 3 * F; m_hits = 0;
        m_level = (m_level > 0) ? m_level - 1 : 0;
      end else if (h) begin
        m_hits = (m_hits + 1) % H;
        if (m_hits == 0 && m_level < MAXL) m_level = m_level + 1;
      end else if (rise) begin
        m_state = 3;
      end
    end else begin
      if (rise) m_state = 2;
    end
  endtask

  function automatic logic [16:0] model_outputs();
    int cd;
    cd = (m_state == 1) ? (m_left + F - 1) / F : 0;
    return {2'(m_state), 1'(m_state != 2), 3'(m_level), 2'(cd), 1'(m_serve),
            4'(BB + m_level), 4'(BP + m_level / 2)};
  endfunction

  // One clock: drive inputs, step model at the edge, settle 1 time unit.
  task automatic apply(input bit ft, ng, ab, h, m);
    bus.frame_tick = ft; bus.new_game = ng; bus.abort = ab;
    bus.hit = h; bus.miss = m; bus.pause_btn = pb_lvl;
    @(posedge clk);
    model_step(ft, ng, ab, h, m, pb_lvl);
    #1;
    bus.frame_tick = 0; bus.new_game = 0; bus.abort = 0; bus.hit = 0; bus.miss = 0;
  endtask

  task automatic go_run();
    apply(0, 1, 0, 0, 0);
    for (int t = 0; t < 3 * F; t++) apply(1, 0, 0, 0, 0);
  endtask

  task automatic hit_n(input int n);
    for (int i = 0; i < n; i++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) apply(1'($urandom % 2), 0, 0, 0, 0);
      apply(1'($urandom % 2), 0, 0, 1, 0);
    end
  endtask

  task automatic test_reset();
    model_reset();
    bus.frame_tick = 0; bus.new_game = 0; bus.abort = 0; bus.hit = 0; bus.miss = 0;
    bus.pause_btn = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({bus.state, bus.freeze, bus.level, bus.countdown, bus.serve_go, bus.ball_speed, bus.paddle_speed}
        !== {2'd0, 1'b1, 3'd0, 2'd0, 1'b0, 4'(BB), 4'(BP)}) begin
      errors++;
      $display("FAIL reset_values: got st=%0d frz=%0d lvl=%0d cd=%0d sg=%0d bs=%0d ps=%0d, want 0 1 0 0 0 %0d %0d",
               bus.state, bus.freeze, bus.level, bus.countdown, bus.serve_go, bus.ball_speed, bus.paddle_speed, BB, BP);
    end
    reset = 0;
    apply(0, 0, 0, 0, 0);
  endtask

  task automatic test_countdown();
    int serves;
    serves = 0;
    apply(0, 1, 0, 0, 0);
    vectors++;
    if (bus.state !== 2'd1 || bus.countdown !== 2'd3 || bus.freeze !== 1'b1) begin
      errors++;
      $display("FAIL count_entry: st=%0d cd=%0d frz=%0d, want 1 3 1", bus.state, bus.countdown, bus.freeze);
    end
    for (int t = 1; t <= 3 * F; t++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        apply(0, 0, 0, 1'($urandom % 2), 1'($urandom % 2));
        if (bus.serve_go) serves++;
      end
      apply(1, 0, 0, 1'($urandom % 2), 1'($urandom % 2));
      if (bus.serve_go) serves++;
      vectors++;
      if (t < 3 * F) begin
        if (bus.countdown !== 2'(3 - t / F) || bus.state !== 2'd1) begin
          errors++;
          $display("FAIL countdown_digit: tick %0d cd=%0d st=%0d, want cd=%0d st=1", t, bus.countdown, bus.state, 3 - t / F);
        end
      end else begin
        if (bus.serve_go !== 1'b1 || bus.state !== 2'd2 || bus.freeze !== 1'b0 || bus.countdown !== 2'd0) begin
          errors++;
          $display("FAIL serve_launch: sg=%0d st=%0d frz=%0d cd=%0d, want 1 2 0 0", bus.serve_go, bus.state, bus.freeze, bus.countdown);
        end
      end
    end
    apply(0, 0, 0, 0, 0);
    if (bus.serve_go) serves++;
    vectors++;
    if (serves != 1) begin
      errors++;
      $display("FAIL serve_once: serve_go pulses=%0d, want 1", serves);
    end
  endtask

  task automatic test_hits();
    hit_n(8);
    vectors++;
    if (bus.level !== 3'd2 || bus.ball_speed !== 4'd4 || bus.paddle_speed !== 4'd4) begin
      errors++;
      $display("FAIL hits_8: lvl=%0d bs=%0d ps=%0d, want 2 4 4", bus.level, bus.ball_speed, bus.paddle_speed);
    end
    hit_n(40);
    vectors++;
    if (bus.level !== 3'd7 || bus.ball_speed !== 4'd9 || bus.paddle_speed !== 4'd6) begin
      errors++;
      $display("FAIL hits_saturate: lvl=%0d bs=%0d ps=%0d, want 7 9 6", bus.level, bus.ball_speed, bus.paddle_speed);
    end
  endtask

  task automatic test_miss();
    apply(0, 0, 1, 0, 0);
    go_run();
    hit_n(12);
    apply(0, 0, 0, 0, 1);
    vectors++;
    if (bus.state !== 2'd1 || bus.level !== 3'd2 || bus.countdown !== 2'd3 || bus.ball_speed !== 4'd4) begin
      errors++;
      $display("FAIL miss_l3: st=%0d lvl=%0d cd=%0d bs=%0d, want 1 2 3 4", bus.state, bus.level, bus.countdown, bus.ball_speed);
    end
    apply(0, 0, 1, 0, 0);
    go_run();
    apply(0, 0, 0, 0, 1);
    vectors++;
    if (bus.state !== 2'd1 || bus.level !== 3'd0) begin
      errors++;
      $display("FAIL miss_l0: st=%0d lvl=%0d, want 1 0", bus.state, bus.level);
    end
  endtask

  task automatic test_pause();
    int serves;
    serves = 0;
    apply(0, 0, 1, 0, 0);
    go_run();
    hit_n(5);                       // level 1, one hit banked
    pb_lvl = 1;
    apply(0, 0, 0, 0, 0);
    vectors++;
    if (bus.state !== 2'd3 || bus.freeze !== 1'b1 || bus.countdown !== 2'd0) begin
      errors++;
      $display("FAIL pause_enter: st=%0d frz=%0d cd=%0d, want 3 1 0", bus.state, bus.freeze, bus.countdown);
    end
    for (int i = 0; i < 6; i++) apply(1'($urandom % 2), 0, 0, 1, 0);
    apply(0, 0, 0, 0, 1);
    apply(0, 1, 0, 0, 0);
    vectors++;
    if (bus.state !== 2'd3 || bus.level !== 3'd1) begin
      errors++;
      $display("FAIL pause_hold: st=%0d lvl=%0d, want 3 1", bus.state, bus.level);
    end
    pb_lvl = 0;
    apply(0, 0, 0, 0, 0);
    vectors++;
    if (bus.state !== 2'd3) begin
      errors++;
      $display("FAIL pause_release: st=%0d, want 3", bus.state);
    end
    pb_lvl = 1;
    apply(0, 0, 0, 0, 0);
    if (bus.serve_go) serves++;
    apply(0, 0, 0, 0, 0);
    if (bus.serve_go) serves++;
    vectors++;
    if (bus.state !== 2'd2 || bus.freeze !== 1'b0 || serves != 0) begin
      errors++;
      $display("FAIL pause_resume: st=%0d frz=%0d serves=%0d, want 2 0 0", bus.state, bus.freeze, serves);
    end
    hit_n(3);                        // banked hit + 3 reaches next level
    vectors++;
    if (bus.level !== 3'd2) begin
      errors++;
      $display("FAIL pause_hits_kept: lvl=%0d, want 2", bus.level);
    end
    pb_lvl = 0;
    apply(0, 0, 0, 0, 0);
  endtask

  task automatic test_hit_miss_same();
    hit_n(2);
    apply(0, 0, 0, 1, 1);
    vectors++;
    if (bus.state !== 2'd1 || bus.level !== 3'd1) begin
      errors++;
      $display("FAIL hit_miss_same: st=%0d lvl=%0d, want 1 1", bus.state, bus.level);
    end
    for (int t = 0; t < 3 * F; t++) apply(1, 0, 0, 0, 0);
    hit_n(H - 1);
    vectors++;
    if (bus.level !== 3'd1) begin
      errors++;
      $display("FAIL hit_count_cleared: lvl=%0d after %0d hits, want 1", bus.level, H - 1);
    end
    hit_n(1);
    vectors++;
    if (bus.level !== 3'd2) begin
      errors++;
      $display("FAIL hit_count_wrap: lvl=%0d, want 2", bus.level);
    end
  endtask

  task automatic test_abort();
    apply(0, 0, 1, 0, 0);
    apply(0, 1, 0, 0, 0);
    for (int t = 0; t < F + 10; t++) apply(1, 0, 0, 0, 0);
    vectors++;
    if (bus.countdown !== 2'd2) begin
      errors++;
      $display("FAIL abort_pre_digit: cd=%0d, want 2", bus.countdown);
    end
    apply(1, 0, 1, 0, 0);
    vectors++;
    if (bus.state !== 2'd0 || bus.countdown !== 2'd0 || bus.level !== 3'd0 || bus.freeze !== 1'b1) begin
      errors++;
      $display("FAIL abort_count: st=%0d cd=%0d lvl=%0d frz=%0d, want 0 0 0 1", bus.state, bus.countdown, bus.level, bus.freeze);
    end
    apply(0, 1, 1, 0, 0);
    vectors++;
    if (bus.state !== 2'd0) begin
      errors++;
      $display("FAIL abort_with_new_game: st=%0d, want 0", bus.state);
    end
  endtask

  task automatic test_random();
    logic [16:0] exp_o, got_o;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 29) == 0) pb_lvl = ~pb_lvl;
      apply(1'($urandom % 2), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 199) == 0),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 39) == 0));
      exp_o = model_outputs();
      got_o = {bus.state, bus.freeze, bus.level, bus.countdown, bus.serve_go, bus.ball_speed, bus.paddle_speed};
      vectors++;
      if (got_o !== exp_o) begin
        errors++;
        $display("FAIL random_cycle %0d: got st/frz/lvl/cd/sg/bs/ps=%h, want %h", c, got_o, exp_o);
      end
    end
    pb_lvl = 0;
    apply(0, 0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    apply(0, 0, 1, 0, 0);
    go_run();
    hit_n(9);
    pb_lvl = 1;
    apply(0, 0, 0, 0, 0);
    vectors++;
    if (bus.state !== 2'd3) begin
      errors++;
      $display("FAIL async_pre_pause: st=%0d, want 3", bus.state);
    end
    #2;
    reset = 1;
    #1;
    vectors++;
    if ({bus.state, bus.freeze, bus.level, bus.countdown, bus.serve_go, bus.ball_speed, bus.paddle_speed}
        !== {2'd0, 1'b1, 3'd0, 2'd0, 1'b0, 4'(BB), 4'(BP)}) begin
      errors++;
      $display("FAIL async_reset: got st=%0d frz=%0d lvl=%0d cd=%0d sg=%0d bs=%0d ps=%0d, want 0 1 0 0 0 %0d %0d",
               bus.state, bus.freeze, bus.level, bus.countdown, bus.serve_go, bus.ball_speed, bus.paddle_speed, BB, BP);
    end
    pb_lvl = 0;
    bus.pause_btn = 0;
    repeat (2) @(posedge clk);
    #2;
    reset = 0;
    model_reset();
    apply(0, 0, 0, 0, 0);
    vectors++;
    if (bus.state !== 2'd0 || bus.level !== 3'd0) begin
      errors++;
      $display("FAIL post_reset_idle: st=%0d lvl=%0d, want 0 0", bus.state, bus.level);
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_hits();
    test_miss();
    test_pause();
    test_hit_miss_same();
    test_abort();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
